// File: rtl/mux_stream_arb_pkg.sv
// rtl/mux_stream_arb_pkg.sv - shared mode encodings and pointer wrap helper
package mux_stream_pkg;

    localparam logic MODE_SEL = 1'b0;
    localparam logic MODE_RR  = 1'b1;

    // Wrap is explicit at n-1 so non-power-of-two channel counts stay correct.
    function automatic int next_ptr(input int idx, input int n);
        return (idx == n - 1) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/mux_stream_arb_if.sv
// rtl/mux_stream_arb_if.sv - producer/consumer handshake bundle for mux_stream_arb
interface mux_stream_arb_if #(
    parameter int N    = 8,
    parameter int W    = 8,
    parameter int SELW = $clog2(N)
) ();
    logic              mode;
    logic [SELW-1:0]   sel;
    logic [N-1:0]      in_valid;
    logic [N*W-1:0]    in_data;
    logic [N-1:0]      in_ready;
    logic              out_valid;
    logic [W-1:0]      out_data;
    logic [SELW-1:0]   out_ch;
    logic              out_ready;

    modport slave (
        input  mode, sel, in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, out_ch
    );

    modport master (
        output mode, sel, in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, out_ch
    );
endinterface

// File: rtl/mux_stream_arb_rr.sv
// rtl/mux_stream_arb_rr.sv - round-robin arbiter with wrap-around priority pointer
module rr_arbiter
    import mux_stream_pkg::*;
#(
    parameter  int N    = 8,
    localparam int SELW = $clog2(N)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [N-1:0]    req_i,
    input  logic            upd_en_i,
    output logic [SELW-1:0] grant_o,
    output logic            grant_valid_o
);
    logic [SELW-1:0] ptr_q, ptr_d;
    logic [SELW-1:0] idx;
    int              sum;

    // Search ptr, ptr+1, ..., N-1, 0, ..., ptr-1 and take the first requester.
    always_comb begin
        grant_o       = '0;
        grant_valid_o = 1'b0;
        idx           = '0;
        sum           = 0;
        for (int k = 0; k < N; k++) begin
            sum = int'(ptr_q) + k;
            idx = SELW'((sum >= N) ? sum - N : sum);
            if (!grant_valid_o && req_i[idx]) begin
                grant_valid_o = 1'b1;
                grant_o       = idx;
            end
        end
    end

    always_comb begin
        ptr_d = ptr_q;
        if (upd_en_i) begin
            ptr_d = SELW'(next_ptr(int'(grant_o), N));
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end
endmodule

// File: rtl/mux_stream_arb.sv
// rtl/mux_stream_arb.sv - N:1 stream mux/arbiter with a single registered output stage
module mux_stream_arb
    import mux_stream_pkg::*;
#(
    parameter  int N    = 8,
    parameter  int W    = 8,
    localparam int SELW = $clog2(N)
) (
    input  logic            clk,
    input  logic            rst_n,
    mux_stream_arb_if.slave bus
);
    logic [SELW-1:0] arb_grant;
    logic            arb_valid;
    logic            sel_hit;
    logic [SELW-1:0] grant;
    logic            granted;
    logic            slot_free;
    logic            xfer;
    logic [W-1:0]    grant_data;

    logic            out_valid_q, out_valid_d;
    logic [W-1:0]    out_data_q,  out_data_d;
    logic [SELW-1:0] out_ch_q,    out_ch_d;

    rr_arbiter #(.N(N)) u_rr (
        .clk           (clk),
        .rst_n         (rst_n),
        .req_i         (bus.in_valid),
        .upd_en_i      (xfer && (bus.mode == MODE_RR)),
        .grant_o       (arb_grant),
        .grant_valid_o (arb_valid)
    );

    // Compare against each legal index so a sel >= N can never index past the bus.
    always_comb begin
        sel_hit    = 1'b0;
        grant_data = '0;
        for (int i = 0; i < N; i++) begin
            if (bus.sel == SELW'(i)) begin
                sel_hit = bus.in_valid[i];
            end
            if (grant == SELW'(i)) begin
                grant_data = bus.in_data[i*W +: W];
            end
        end
    end

    assign grant     = (bus.mode == MODE_RR) ? arb_grant : bus.sel;
    assign granted   = (bus.mode == MODE_RR) ? arb_valid : sel_hit;
    assign slot_free = !out_valid_q || bus.out_ready;
    assign xfer      = rst_n && slot_free && granted;

    assign bus.in_ready = xfer ? (N'(1) << grant) : '0;

    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_ch_d    = out_ch_q;
        if (xfer) begin
            out_valid_d = 1'b1;
            out_data_d  = grant_data;
            out_ch_d    = grant;
        end else if (bus.out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_ch_q    <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_ch_q    <= out_ch_d;
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.out_ch    = out_ch_q;
endmodule

// File: tb/tb_mux_stream_arb.sv
// tb/tb_mux_stream_arb.sv - randomized and directed checks of mux_stream_arb against a reference model
module tb_mux_stream_arb;
    localparam int N = 8;
    localparam int W = 8;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    mux_stream_arb_if #(.N(N), .W(W)) bus ();
    mux_stream_arb_if #(.N(6), .W(W)) bus6 ();

    mux_stream_arb #(.N(N), .W(W)) dut  (.clk(clk), .rst_n(rst_n), .bus(bus));
    mux_stream_arb #(.N(6), .W(W)) dut6 (.clk(clk), .rst_n(rst_n), .bus(bus6));

    int tests = 0;
    int fails = 0;

    int         m_ptr;
    logic       m_valid;
    logic [7:0] m_data;
    int         m_ch;

    logic [7:0]  rdy;
    logic [63:0] lanes;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic int model_grant(input logic mode, input int sel, input logic [7:0] v, input int ptr);
        if (mode == 1'b0) begin
            return (sel < N && v[sel]) ? sel : -1;
        end
        for (int k = 0; k < N; k++) begin
            if (v[(ptr + k) % N]) return (ptr + k) % N;
        end
        return -1;
    endfunction

    task automatic model_reset();
        m_ptr   = 0;
        m_valid = 1'b0;
        m_data  = 8'h00;
        m_ch    = 0;
    endtask

    // Called at a negedge: drive inputs, check in_ready, clock, check the output register.
    task automatic step(input logic mode, input logic [2:0] sel, input logic [7:0] v,
                        input logic [63:0] d, input logic ordy, output logic [7:0] rdy_seen);
        int         g;
        logic [7:0] exp_rdy;
        bus.mode = mode; bus.sel = sel; bus.in_valid = v; bus.in_data = d; bus.out_ready = ordy;
        #1;
        g = model_grant(mode, int'(sel), v, m_ptr);
        exp_rdy = (g >= 0 && (!m_valid || ordy)) ? 8'(1 << g) : 8'h00;
        rdy_seen = bus.in_ready;
        chk("in_ready", {56'd0, bus.in_ready}, {56'd0, exp_rdy});
        @(posedge clk);
        if (exp_rdy != 8'h00) begin
            m_valid = 1'b1;
            m_data  = d[g*8 +: 8];
            m_ch    = g;
            if (mode) m_ptr = (g + 1) % N;
        end else if (ordy) begin
            m_valid = 1'b0;
        end
        @(negedge clk);
        chk("out_valid", {63'd0, bus.out_valid}, {63'd0, m_valid});
        chk("out_data", {56'd0, bus.out_data}, {56'd0, m_data});
        chk("out_ch", {61'd0, bus.out_ch}, 64'(m_ch));
    endtask

    task automatic reset_check(input string tag);
        #1;
        chk({tag, "_out_valid"}, {63'd0, bus.out_valid}, 64'd0);
        chk({tag, "_out_data"}, {56'd0, bus.out_data}, 64'd0);
        chk({tag, "_out_ch"}, {61'd0, bus.out_ch}, 64'd0);
        chk({tag, "_in_ready"}, {56'd0, bus.in_ready}, 64'd0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        model_reset();
        reset_check("reset");
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        lanes = 64'h1716_1514_1312_1110;
        bus.mode = 1'b0; bus.sel = '0; bus.in_valid = '0; bus.in_data = '0; bus.out_ready = 1'b0;
        bus6.mode = 1'b0; bus6.sel = '0; bus6.in_valid = '0; bus6.in_data = '0; bus6.out_ready = 1'b1;
        rst_n = 1'b0;
        model_reset();
        @(negedge clk);
        do_reset();

        // SEL mode, channel 5.
        step(1'b0, 3'd5, 8'h20, 64'h0000_A500_0000_0000, 1'b1, rdy);
        chk("sel5_in_ready", {56'd0, rdy}, 64'h20);
        chk("sel5_out_data", {56'd0, bus.out_data}, 64'hA5);
        chk("sel5_out_ch", {61'd0, bus.out_ch}, 64'd5);

        // SEL gating: selected channel not valid.
        do_reset();
        step(1'b0, 3'd3, 8'hF7, lanes, 1'b1, rdy);
        chk("sel3_in_ready", {56'd0, rdy}, 64'h0);
        chk("sel3_out_valid", {63'd0, bus.out_valid}, 64'd0);

        // N=6 instance: out-of-range select gets no grant.
        bus6.mode = 1'b0; bus6.sel = 3'd7; bus6.in_valid = 6'h3F; bus6.in_data = 48'hAA_BB_CC_DD_EE_FF;
        #1;
        chk("n6_sel7_in_ready", {58'd0, bus6.in_ready}, 64'h0);
        bus6.sel = 3'd6;
        #1;
        chk("n6_sel6_in_ready", {58'd0, bus6.in_ready}, 64'h0);
        bus6.sel = 3'd5;
        #1;
        chk("n6_sel5_in_ready", {58'd0, bus6.in_ready}, 64'h20);
        @(negedge clk);
        chk("n6_sel5_out_data", {56'd0, bus6.out_data}, 64'hAA);
        chk("n6_sel5_out_ch", {61'd0, bus6.out_ch}, 64'd5);

        // RR fairness: all requesting, one word per cycle in index order.
        do_reset();
        for (int k = 0; k < 16; k++) begin
            step(1'b1, 3'd0, 8'hFF, lanes, 1'b1, rdy);
            chk("rr_fair_in_ready", {56'd0, rdy}, 64'(1 << (k % 8)));
            chk("rr_fair_out_ch", {61'd0, bus.out_ch}, 64'(k % 8));
            chk("rr_fair_out_valid", {63'd0, bus.out_valid}, 64'd1);
        end

        // RR wrap and skip from ptr=6.
        do_reset();
        step(1'b1, 3'd0, 8'h20, lanes, 1'b1, rdy);
        step(1'b1, 3'd0, 8'h05, lanes, 1'b1, rdy);
        chk("rr_wrap_g0", {56'd0, rdy}, 64'h01);
        step(1'b1, 3'd0, 8'h05, lanes, 1'b1, rdy);
        chk("rr_wrap_g2", {56'd0, rdy}, 64'h04);
        step(1'b1, 3'd0, 8'h05, lanes, 1'b1, rdy);
        chk("rr_wrap_g0b", {56'd0, rdy}, 64'h01);

        // Back-pressure then simultaneous consume + capture.
        do_reset();
        step(1'b1, 3'd0, 8'hFF, lanes, 1'b1, rdy);
        for (int k = 0; k < 4; k++) begin
            step(1'b1, 3'd0, 8'hFF, lanes, 1'b0, rdy);
            chk("bp_in_ready", {56'd0, rdy}, 64'h0);
            chk("bp_out_data", {56'd0, bus.out_data}, 64'h10);
            chk("bp_out_ch", {61'd0, bus.out_ch}, 64'd0);
        end
        step(1'b1, 3'd0, 8'hFF, lanes, 1'b1, rdy);
        chk("bp_release_in_ready", {56'd0, rdy}, 64'h02);
        chk("bp_release_out_valid", {63'd0, bus.out_valid}, 64'd1);
        chk("bp_release_out_data", {56'd0, bus.out_data}, 64'h11);

        // Randomized traffic across both modes.
        for (int k = 0; k < 600; k++) begin
            step(1'($urandom_range(0, 1)), 3'($urandom), ($urandom_range(0, 3) == 0) ? 8'hFF : 8'($urandom),
                 {$urandom, $urandom}, ($urandom_range(0, 3) != 0), rdy);
        end

        // Asynchronous reset while a word is held.
        step(1'b0, 3'd2, 8'h04, lanes, 1'b1, rdy);
        chk("pre_reset_out_valid", {63'd0, bus.out_valid}, 64'd1);
        bus.in_valid = 8'hFF; bus.out_ready = 1'b0;
        #2;
        rst_n = 1'b0;
        model_reset();
        reset_check("midreset");
        @(negedge clk);
        rst_n = 1'b1;
        step(1'b1, 3'd0, 8'hFF, lanes, 1'b1, rdy);
        chk("post_reset_ptr0", {56'd0, rdy}, 64'h01);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
